// File: rtl/spi_rom_reader.sv
// SPI Mode 0 ROM read engine: READ command, address, then N bytes.
// Bytes stream out as single-cycle strobes; sclk runs at clk/2.
module spi_rom_reader #(
  parameter logic [7:0] READ_CMD  = 8'h03,
  parameter int         ADDR_BITS = 24,
  parameter int         LEN_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [LEN_BITS-1:0]  len,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 byte_valid,
  output logic [7:0]           byte_data,
  output logic                 spi_cs,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam int HDR = 8 + ADDR_BITS;
  localparam int CW  = $clog2(HDR + 8 * (2 ** LEN_BITS - 1) + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t         state_q, state_d;
  logic [HDR-1:0] sh_q, sh_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  total_q, total_d;
  logic [2:0]     bcnt_q, bcnt_d;
  logic [7:0]     rx_q, rx_d, data_d;
  logic           cs_d, sclk_d, mosi_d;
  logic           busy_d, done_d, bv_d;
  logic           data_phase, last_bit;

  assign data_phase = cnt_q >= CW'(HDR);
  assign last_bit   = cnt_q == total_q - CW'(1);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    bcnt_d  = bcnt_q;
    rx_d    = rx_q;
    data_d  = byte_data;
    cs_d    = spi_cs;
    sclk_d  = spi_sclk;
    mosi_d  = spi_mosi;
    busy_d  = busy;
    done_d  = 1'b0;
    bv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cs_d   = 1'b0;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        if (start && !abort) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d        = SHIFT;
            cs_d           = 1'b1;
            busy_d         = 1'b1;
            {mosi_d, sh_d} = {READ_CMD, addr, 1'b0};
            cnt_d          = '0;
            bcnt_d         = '0;
            total_d        = CW'(HDR) + CW'({len, 3'b000});
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (!spi_sclk) begin
          sclk_d = 1'b1;
          if (data_phase) rx_d = {rx_q[6:0], spi_miso};
        end else begin
          sclk_d = 1'b0;
          cnt_d  = cnt_q + CW'(1);
          if (data_phase) begin
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              bv_d   = 1'b1;
              data_d = rx_q;
            end
          end
          if (last_bit) begin
            state_d = GAP;
            cs_d    = 1'b0;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // zeros shift in behind the address, so data bits drive 0
            {mosi_d, sh_d} = {sh_q, 1'b0};
          end
        end
      end
      GAP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      total_q    <= '0;
      bcnt_q     <= '0;
      rx_q       <= '0;
      byte_data  <= '0;
      spi_cs     <= 1'b0;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      total_q    <= total_d;
      bcnt_q     <= bcnt_d;
      rx_q       <= rx_d;
      byte_data  <= data_d;
      spi_cs     <= cs_d;
      spi_sclk   <= sclk_d;
      spi_mosi   <= mosi_d;
      busy       <= busy_d;
      done       <= done_d;
      byte_valid <= bv_d;
    end
  end

endmodule

// File: tb/tb_spi_rom_reader.sv
// Bench for spi_rom_reader: SPI slave ROM model plus a per-cycle
// transaction-level timing model, directed cases and random traffic.
module tb_spi_rom_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] addr = '0;
  logic [7:0]  len = '0;
  logic        busy, done, byte_valid;
  logic [7:0]  byte_data;
  logic        spi_cs, spi_sclk, spi_mosi;
  bit          spi_miso;

  always #5 clk = ~clk;

  spi_rom_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .addr       (addr),
    .len        (len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .spi_cs     (spi_cs),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  // ROM contents returned after the 32 header bits
  logic [7:0]  sdata [256];
  int          rc;
  int          idx;
  logic [31:0] mosi_sh = '0;
  logic [31:0] hdr_cap = '0;

  always @(spi_sclk or spi_cs) begin
    if (!spi_cs) begin
      rc = 0;
      spi_miso = 1'($urandom);
    end else if (spi_sclk) begin
      mosi_sh = {mosi_sh[30:0], spi_mosi};
      rc++;
      if (rc == 32) hdr_cap = mosi_sh;
    end else if (rc >= 32) begin
      idx = rc - 32;
      spi_miso = sdata[idx / 8][7 - idx % 8];
    end else begin
      spi_miso = 1'($urandom);
    end
  end

  int          cyc = 0;
  bit          act = 0;
  bit          zd = 0;
  int          t0 = 0;
  int          nb = 0;
  logic [31:0] mhdr = '0;
  logic [7:0]  ed = '0;
  int          vectors = 0;
  int          miscompares = 0;
  int          cs_high = 0;
  int          done_cnt = 0;
  int          done_rel = 0;
  int          bv_rel[$];
  logic [7:0]  bv_dat[$];

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h",
               nm, cyc, got, exp);
    end
  endtask

  task automatic step();
    int   c_old, rel, k;
    logic ecs, esclk, emosi, ebusy, edone, ebv;
    @(posedge clk);
    c_old = cyc;
    cyc++;
    zd = 0;
    if (reset) begin
      act = 0;
      ed = '0;
    end else if (act) begin
      if (abort || (c_old - t0 == 2 * nb + 1)) act = 0;
    end else if (start && !abort) begin
      if (len == 0) zd = 1;
      else begin
        act  = 1;
        t0   = c_old;
        nb   = 32 + 8 * int'(len);
        mhdr = {8'h03, addr};
      end
    end
    ecs = 0; esclk = 0; emosi = 0; ebusy = 0; edone = zd; ebv = 0;
    if (act) begin
      rel = cyc - t0;
      if (rel >= 1 && rel <= 2 * nb) begin
        ecs   = 1;
        ebusy = 1;
        esclk = (rel % 2 == 0);
        k     = (rel - 1) / 2;
        emosi = (k < 32) ? mhdr[31 - k] : 1'b0;
      end else if (rel == 2 * nb + 1) begin
        ebusy = 1;
        edone = 1;
      end
      if (rel >= 81 && rel <= 2 * nb + 1 && (rel - 81) % 16 == 0) begin
        ebv = 1;
        ed  = sdata[(rel - 81) / 16];
      end
    end
    #1;
    chk("spi_cs", 32'(spi_cs), 32'(ecs));
    chk("spi_sclk", 32'(spi_sclk), 32'(esclk));
    chk("spi_mosi", 32'(spi_mosi), 32'(emosi));
    chk("busy", 32'(busy), 32'(ebusy));
    chk("done", 32'(done), 32'(edone));
    chk("byte_valid", 32'(byte_valid), 32'(ebv));
    chk("byte_data", 32'(byte_data), 32'(ed));
    if (byte_valid) begin
      bv_rel.push_back(cyc - t0);
      bv_dat.push_back(byte_data);
    end
    if (done) begin
      done_rel = cyc - t0;
      done_cnt++;
    end
    if (spi_cs) cs_high++;
  endtask

  task automatic pulse(input logic [23:0] a, input logic [7:0] l);
    addr  = a;
    len   = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      step();
      if (done) break;
    end
    if (i == maxc) chk("done_timeout", 32'(i), 32'(0));
  endtask

  task automatic check_len2(input string tag);
    chk({tag, "_bv_count"}, 32'(bv_rel.size()), 32'd2);
    if (bv_rel.size() >= 2) begin
      chk({tag, "_bv0_cycle"}, 32'(bv_rel[0]), 32'd81);
      chk({tag, "_bv0_data"}, 32'(bv_dat[0]), 32'hA5);
      chk({tag, "_bv1_cycle"}, 32'(bv_rel[1]), 32'd97);
      chk({tag, "_bv1_data"}, 32'(bv_dat[1]), 32'h3C);
    end
    chk({tag, "_done_cycle"}, 32'(done_rel), 32'd97);
    chk({tag, "_mosi_header"}, hdr_cap, 32'h03123456);
    chk({tag, "_cs_high_cycles"}, 32'(cs_high), 32'd96);
  endtask

  initial begin
    int ts, t_first, guard;
    logic [7:0] l;

    for (int j = 0; j < 256; j++) sdata[j] = 8'($urandom);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    cs_high = 0;
    repeat (10) step();
    chk("idle_cs_never_high", 32'(cs_high), 32'd0);

    sdata[0] = 8'hA5;
    sdata[1] = 8'h3C;
    bv_rel.delete(); bv_dat.delete(); cs_high = 0;
    pulse(24'h123456, 8'd2);
    wait_done(200);
    check_len2("read2");
    step();
    chk("busy_low_after", 32'(busy), 32'd0);

    t_first = t0;
    bv_rel.delete(); bv_dat.delete(); cs_high = 0;
    pulse(24'h123456, 8'd2);
    chk("b2b_start_offset", 32'(t0 - t_first), 32'd98);
    wait_done(200);
    check_len2("b2b");
    step();

    pulse(24'hABCDEF, 8'd0);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_cs", 32'(spi_cs), 32'd0);
    repeat (4) step();

    for (int j = 0; j < 256; j++) sdata[j] = 8'($urandom);
    pulse(24'($urandom), 8'd4);
    ts = t0;
    while (cyc < ts + 20) step();
    pulse(24'hFFFFFF, 8'd7);
    while (cyc < ts + 40) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_cs", 32'(spi_cs), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    bv_rel.delete(); bv_dat.delete(); done_cnt = 0;
    repeat (100) step();
    chk("abort_no_bv", 32'(bv_rel.size()), 32'd0);
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    pulse(24'($urandom), 8'd3);
    ts = t0;
    while (cyc < ts + 50) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_outputs",
        {23'd0, busy, done, byte_valid, spi_cs, spi_sclk, spi_mosi, 3'd0},
        32'd0);
    chk("rst_byte_data", 32'(byte_data), 32'd0);
    step();
    pulse(24'h00F00D, 8'd1);
    wait_done(200);
    chk("after_rst_done_cycle", 32'(done_rel), 32'd81);
    step();

    for (int it = 0; it < 40; it++) begin
      for (int j = 0; j < 256; j++) sdata[j] = 8'($urandom);
      if (it == 5) l = 8'd255;
      else if ($urandom % 8 == 0) l = 8'd0;
      else l = 8'($urandom_range(1, 6));
      pulse(24'($urandom), l);
      guard = 0;
      while ((act || zd) && guard < 5000) begin
        start = ($urandom % 25 == 0);
        addr  = 24'($urandom);
        len   = 8'($urandom_range(1, 6));
        abort = ($urandom % 300 == 0);
        step();
        guard++;
      end
      start = 1'b0;
      abort = 1'b0;
      if (guard >= 5000) chk("random_timeout", 32'(guard), 32'd0);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
